inv_round_engine: RTL and testbench
===================================

Name: inv_round_engine

Overview:
- Iterative AES-variant decryption core, the inverse of the encryption round datapath (subBytes -> nov_shiftrow -> bit_perm -> addroundkey).
- Takes one 128-bit ciphertext and runs NR inverse rounds, one per clock, on a single shared datapath.
- Reads round keys from an external combinational key store through an index port.
- Returns the plaintext through a valid/ready output handshake.

Parameters:
- NR, 10, number of rounds; key store holds NR+1 keys (index 0..NR).
- DW, 128, state/key width; fixed at 128, parameter exists for lint only.
- KW, 4, key index width; must satisfy 2^KW > NR.

Ports:
- clk  input  1  clock, rising edge.
- rst_an  input  1  reset; synchronous, active-high.
- ct_in  input  128  ciphertext.
- in_valid  input  1  ct_in valid.
- in_ready  output  1  engine can accept ct_in.
- key_idx  output  KW  round key index requested this cycle.
- key_in  input  128  round key for key_idx; combinational, same cycle.
- pt_out  output  128  plaintext result.
- out_valid  output  1  pt_out valid.
- out_ready  input  1  consumer accepts pt_out.

Behaviour:
- Inverse round: s_next = inv_subBytes(inv_nov_shiftrow(inv_bit_perm(s ^ key_in))).
  - Each primitive is the exact combinational inverse of its forward counterpart.
  - All NR rounds share the same structure; there is no special last round.
- Full decrypt: for r = NR down to 1, apply the inverse round with key r; then pt = s ^ key 0.
- States: IDLE, ROUND, FINAL, DONE.
  - IDLE: in_ready=1, key_idx=NR. On in_valid: state_reg<=ct_in, rcnt<=NR, go to ROUND.
  - ROUND: key_idx=rcnt; state_reg<=inverse round of state_reg; rcnt<=rcnt-1. Go to FINAL when rcnt==1.
  - FINAL: key_idx=0; pt_reg<=state_reg^key_in; go to DONE.
  - DONE: out_valid=1. On out_ready go to IDLE. Otherwise hold; pt_out stays stable.
- Latency: accept edge E0; ROUND on edges E1..E10; FINAL on E11; out_valid high from E11. That is 11 cycles for NR=10 (NR+1 in general).
- Throughput with out_ready tied high: one block per NR+3 cycles. in_ready is low in ROUND, FINAL and DONE; no overlap between blocks.
- in_valid while busy: ignored, no side effects. The producer must hold ct_in until it sees in_ready.
- Reset values: state=IDLE, in_ready=1, out_valid=0, pt_out=0, key_idx=NR, rcnt=0, state_reg=0.
- Reset mid-operation: abort on the next edge, discard the block, return to reset values. No partial output appears.
- key_in is sampled only on ROUND/FINAL edges; its value in IDLE/DONE is don't-care.
- rcnt is KW bits wide and never wraps; the ROUND-exit check happens before the decrement below 1.

Optional Feature:
- Macro INV_ROUND_FLUSH_EN.
- Defined: adds input port flush (1 bit, synchronous).
  - flush=1 in any state: next edge gives state=IDLE, out_valid=0, pt_out=0, rcnt=0.
  - flush has priority over in_valid and out_ready in the same cycle.
  - rst_an has priority over flush.
- Undefined: no flush port. The only way to abort is rst_an.

Test Plan:
- Round-trip: pt=128'h00112233445566778899aabbccddeeff; key r = 128'h000102030405060708090a0b0c0d0e0f ^ {16{r[7:0]}}. Get ct from the forward round chain (initial addroundkey with key 0, rounds 1..10). Decrypt -> pt_out equals pt, out_valid rises exactly 11 cycles after the accept edge.
- Key sequence: during the same run, check key_idx cycle by cycle: 10,9,...,1 in ROUND, then 0 in FINAL. key_idx=10 in IDLE.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> pt_out and out_valid stable, in_ready=0, an in_valid pulse is ignored. Raise out_ready -> in_ready=1 next cycle.
- Back-to-back: two blocks with in_valid held high and out_ready=1 -> both plaintexts correct, second accept exactly 13 cycles after the first.
- Reset mid-op: assert rst_an for 1 cycle at the 5th ROUND cycle -> next cycle in_ready=1, out_valid=0, pt_out=0. A following fresh block decrypts correctly.
- INV_ROUND_FLUSH_EN: flush in DONE with out_ready=1 in the same cycle -> IDLE, no handshake counted. flush together with in_valid in IDLE -> block not accepted.

Source files
------------

// File: rtl/inv_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : inv_round_engine
// Purpose  : Iterative decryption core for an AES-variant block cipher.
//            One inverse round per clock on a single shared datapath:
//              s_next = inv_sub(inv_shiftrow(inv_perm(s ^ key)))
//            After NR rounds (keys NR..1), pt = s ^ key[0].
//
//            Forward primitives that this core inverts:
//              subBytes     : AES S-box applied to every byte.
//              nov_shiftrow : bytes in column-major order (byte i is
//                             bits [127-8i -: 8], row = i%4, col = i/4);
//                             out[r][c] = in[r][(c+r)%4].
//              bit_perm     : out[(7*i) % 128] = in[i]  (bit i = vector bit i).
//
// Ports    : clk        - clock, rising edge
//            rst_an     - synchronous active-high reset
//            flush      - synchronous abort (only with INV_ROUND_FLUSH_EN)
//            ct_in      - ciphertext, qualified by in_valid
//            in_valid   - ct_in valid
//            in_ready   - engine idle, ct_in will be accepted
//            key_idx    - round-key index requested this cycle
//            key_in     - round key for key_idx (combinational key store)
//            pt_out     - plaintext result, qualified by out_valid
//            out_valid  - pt_out valid
//            out_ready  - consumer accepts pt_out
//
// Options  : `define INV_ROUND_FLUSH_EN adds the flush input.
// Revision : 1.0 - initial release
// ============================================================================
module inv_round_engine #(
  parameter int NR = 10,
  parameter int DW = 128,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_an,
`ifdef INV_ROUND_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [DW-1:0] ct_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [KW-1:0] key_idx,
  input  logic [DW-1:0] key_in,
  output logic [DW-1:0] pt_out,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [KW-1:0] NR_K = KW'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [KW-1:0] rcnt;
  logic [DW-1:0] state_reg;

  // --------------------------------------------------------------------------
  // GF(2^8) arithmetic, AES polynomial x^8+x^4+x^3+x+1
  // --------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, b);   // 254 = 8'b1111_1110
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // --------------------------------------------------------------------------
  // Inverse round datapath
  // --------------------------------------------------------------------------
  logic [DW-1:0] keyed;
  logic [DW-1:0] permuted;
  logic [DW-1:0] shifted;
  logic [DW-1:0] round_out;

  assign keyed = state_reg ^ key_in;

  // Forward moved bit i to 7*i mod 128, so read it back from there.
  for (genvar i = 0; i < DW; i++) begin : g_perm
    assign permuted[i] = keyed[(7 * i) % DW];
  end

  // Forward took out[r][c] = in[r][(c+r)%4]; inverse is in[r][(c-r)%4].
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign shifted[DW-1-8*(r+4*c) -: 8] =
             permuted[DW-1-8*(r+4*((c+4-r)%4)) -: 8];
    end
  end

  for (genvar i = 0; i < DW/8; i++) begin : g_sub
    assign round_out[DW-1-8*i -: 8] = inv_sbox(shifted[DW-1-8*i -: 8]);
  end

  // --------------------------------------------------------------------------
  // Control FSM; all outputs registered
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_an) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      pt_out    <= '0;
      key_idx   <= NR_K;
      rcnt      <= '0;
      state_reg <= '0;
    end
`ifdef INV_ROUND_FLUSH_EN
    else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      pt_out    <= '0;
      key_idx   <= NR_K;
      rcnt      <= '0;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= ct_in;
            rcnt      <= NR_K;
            key_idx   <= NR_K;
            in_ready  <= 1'b0;
            state     <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          rcnt      <= rcnt - 1'b1;
          // Key index tracks rcnt one cycle ahead; reaches 0 for FINAL.
          key_idx   <= rcnt - 1'b1;
          if (rcnt == KW'(1)) state <= FINAL;
        end
        FINAL: begin
          pt_out    <= state_reg ^ key_in;
          out_valid <= 1'b1;
          key_idx   <= NR_K;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_round_engine
// Purpose  : Self-checking bench for inv_round_engine. Ciphertexts come from
//            an independent forward-cipher model (S-box built by the classic
//            generator loop); expected plaintexts go through a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_round_engine;

  localparam int NR = 10;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst_an;
  logic          flush;
  logic [127:0]  ct_in;
  logic          in_valid;
  logic          in_ready;
  logic [KW-1:0] key_idx;
  logic [127:0]  key_in;
  logic [127:0]  pt_out;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  key_base;

  // Combinational key store: key r = base ^ {16{r}}
  assign key_in = key_base ^ {16{{4'h0, key_idx}}};

  always #5 clk = ~clk;

  inv_round_engine #(.NR(NR), .DW(128), .KW(KW)) dut (
    .clk       (clk),
    .rst_an    (rst_an),
`ifdef INV_ROUND_FLUSH_EN
    .flush     (flush),
`endif
    .ct_in     (ct_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_idx   (key_idx),
    .key_in    (key_in),
    .pt_out    (pt_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox[256];

  typedef struct {
    logic [127:0] pt;     // plaintext encrypted to form the input block
    logic [127:0] base;   // key-store base
    logic [127:0] exp_pt; // required pt_out
  } vec_t;
  vec_t tab[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [127:0] rkey(input logic [127:0] base, input int r);
    logic [7:0] rb;
    rb = 8'(r);
    return base ^ {16{rb}};
  endfunction

  function automatic logic [127:0] fwd_round(input logic [127:0] s, input logic [127:0] k);
    logic [127:0] a, b, o;
    for (int i = 0; i < 16; i++) a[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[127-8*(r+4*c) -: 8] = a[127-8*(r+4*((c+r)%4)) -: 8];
    for (int i = 0; i < 128; i++) o[(7*i)%128] = b[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] base);
    logic [127:0] s;
    s = pt ^ rkey(base, 0);
    for (int r = 1; r <= NR; r++) s = fwd_round(s, rkey(base, r));
    return s;
  endfunction

  task automatic pop_chk(input string name);
    logic [127:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %h expected none (scoreboard empty)", name, pt_out);
    end else begin
      e = exp_q.pop_front();
      chk(name, pt_out, e);
    end
  endtask

  // Starts a block from IDLE; returns at the negedge where out_valid is first
  // seen (or after a bounded wait), with lat = cycles since the accept edge.
  task automatic start_block(input logic [127:0] pt, input logic [127:0] base, output int lat);
    int w;
    key_base = base;
    ct_in    = encrypt(pt, base);
    w = 0;
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_key_idx", key_idx, NR);
    in_valid = 1'b1;
    exp_q.push_back(pt);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_in_ready", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat <= NR) chk("key_idx_seq", key_idx, (lat < NR) ? (NR - lat) : 0);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_block();
    pop_chk("pt_out");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_in_ready", in_ready, 1'b1);
    chk("post_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    logic [127:0] held;
    logic [127:0] ct1, ct2;
    logic [127:0] pts[2];
    int acc[2];
    int nacc, nout;
    bit acc_now;

    build_sbox();
    rst_an = 1'b1; flush = 1'b0; ct_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    key_base = '0;

    tab[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               128'h00112233445566778899aabbccddeeff};
    tab[1] = '{128'h0, 128'h0, 128'h0};
    tab[2] = '{{128{1'b1}}, 128'h2b7e151628aed2a6abf7158809cf4f3c, {128{1'b1}}};
    tab[3] = '{128'h3243f6a8885a308d313198a2e0370734, 128'hffeeddccbbaa99887766554433221100,
               128'h3243f6a8885a308d313198a2e0370734};

    repeat (2) @(negedge clk);
    rst_an = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_pt_out", pt_out, 128'h0);
    chk("rst_key_idx", key_idx, NR);

    // Table-driven round trips with latency and key-sequence checks
    for (int v = 0; v < 4; v++) begin
      start_block(tab[v].pt, tab[v].base, lat);
      chk("latency", lat, NR + 1);
      exp_q[exp_q.size()-1] = tab[v].exp_pt;
      finish_block();
    end

    // Backpressure: hold out_ready low for 20 cycles, pulse in_valid mid-way
    start_block(tab[3].pt, tab[0].base, lat);
    chk("bp_latency", lat, NR + 1);
    held = pt_out;
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_pt_stable", pt_out, held);
      chk("bp_in_ready", in_ready, 1'b0);
      if (i == 5) begin
        ct_in    = 128'hdeadbeef;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    finish_block();

    // Back-to-back with in_valid held high and out_ready tied high
    key_base = tab[2].base;
    pts[0] = 128'h0f0e0d0c0b0a09080706050403020100;
    pts[1] = 128'h55aa55aa0123456789abcdeffedcba98;
    ct1 = encrypt(pts[0], key_base);
    ct2 = encrypt(pts[1], key_base);
    ct_in = ct1; in_valid = 1'b1; out_ready = 1'b1;
    nacc = 0; nout = 0; acc_now = 1'b0; acc[0] = 0; acc[1] = 0;
    for (int cyc = 0; cyc < 60 && nout < 2; cyc++) begin
      if (out_valid) begin
        pop_chk("b2b_pt_out");
        nout++;
      end
      if (in_valid && in_ready && nacc < 2) begin
        acc[nacc] = cyc;
        exp_q.push_back(pts[nacc]);
        nacc++;
        acc_now = 1'b1;
      end
      @(negedge clk);
      if (acc_now) begin
        if (nacc == 1) ct_in = ct2;
        else in_valid = 1'b0;
        acc_now = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_outputs", nout, 2);
    chk("b2b_spacing", acc[1] - acc[0], NR + 3);

    // Reset during the 5th ROUND cycle
    key_base = tab[0].base;
    ct_in = encrypt(tab[0].pt, key_base);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_an = 1'b1;
    @(negedge clk);
    rst_an = 1'b0;
    exp_q.delete();
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_pt_out", pt_out, 128'h0);
    chk("mid_rst_key_idx", key_idx, NR);
    start_block(tab[2].pt, tab[2].base, lat);
    chk("post_rst_latency", lat, NR + 1);
    finish_block();

`ifdef INV_ROUND_FLUSH_EN
    // flush in DONE together with out_ready
    start_block(tab[0].pt, tab[0].base, lat);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    chk("flush_done_out_valid", out_valid, 1'b0);
    chk("flush_done_pt_out", pt_out, 128'h0);
    chk("flush_done_in_ready", in_ready, 1'b1);
    // flush together with in_valid in IDLE: no accept
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_in_ready", in_ready, 1'b1);
    repeat (NR + 2) @(negedge clk);
    chk("flush_idle_out_valid", out_valid, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
